fp_mul_norm_round: RTL and testbench

- Downstream stage of the cascaded significand multiplier.
- Consumes the 2N-bit significand product plus the pre-computed sign, biased exponent sum and special-case flags, and emits a packed IEEE-754-style result.
- Normalizes, rounds to nearest-even, and handles overflow, underflow and special values.
- Two-stage valid/ready pipeline; full throughput under backpressure.

---
 rtl/fp_mul_norm_round.sv | 173 +++++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
// Normalize / round-to-nearest-even / pack stage following the significand multiplier.
// Two registered stages with valid/ready flow control; specials override the arithmetic.
module fp_mul_norm_round #(
    parameter int N  = 11,
    parameter int EW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N-1:0]    in_prod,
    input  logic [EW+1:0]     in_exp,
    input  logic              in_sign,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+N-1:0]   out_result,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact
);

    localparam int PW = 2 * N;
    // One extra bit over the input exponent so +1 (normalize) and +1 (round carry) never wrap.
    localparam int XW = EW + 3;
    localparam logic signed [XW-1:0] EXP_ONE  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
    localparam logic signed [XW-1:0] EXP_MAX  = {{(XW-EW){1'b0}}, {EW{1'b1}}};

    logic                  s1_load_s;
    logic                  s2_load_s;
    logic signed [XW-1:0]  in_exp_x_s;
    logic [N-1:0]          norm_mant_s;
    logic                  norm_guard_s;
    logic                  norm_sticky_s;
    logic signed [XW-1:0]  norm_exp_s;

    logic                  s1_valid_r;
    logic [N-1:0]          s1_mant_r;
    logic                  s1_guard_r;
    logic                  s1_sticky_r;
    logic signed [XW-1:0]  s1_exp_r;
    logic                  s1_sign_r;
    logic                  s1_nan_r;
    logic                  s1_inf_r;
    logic                  s1_zero_r;

    logic                  round_up_s;
    logic                  carry_s;
    logic [N-2:0]          frac_s;
    logic signed [XW-1:0]  exp_fin_s;
    logic [EW+N-1:0]       res_s;
    logic                  ovf_s;
    logic                  unf_s;
    logic                  inexact_s;

    logic                  out_valid_r;
    logic [EW+N-1:0]       out_result_r;
    logic                  out_ovf_r;
    logic                  out_unf_r;
    logic                  out_inexact_r;

    assign s2_load_s  = !out_valid_r || out_ready;
    assign s1_load_s  = !s1_valid_r || s2_load_s;
    assign in_ready   = s1_load_s;
    assign in_exp_x_s = {in_exp[EW+1], in_exp};

    // Stage-1 normalization: pick the N-bit window under the leading one.
    always_comb begin
        norm_mant_s   = in_prod[PW-2:N-1];
        norm_guard_s  = in_prod[N-2];
        norm_sticky_s = |in_prod[N-3:0];
        norm_exp_s    = in_exp_x_s;
        if (in_prod[PW-1]) begin
            norm_mant_s   = in_prod[PW-1:N];
            norm_guard_s  = in_prod[N-1];
            norm_sticky_s = |in_prod[N-2:0];
            norm_exp_s    = in_exp_x_s + EXP_ONE;
        end else begin
            norm_mant_s   = in_prod[PW-2:N-1];
            norm_guard_s  = in_prod[N-2];
            norm_sticky_s = |in_prod[N-3:0];
            norm_exp_s    = in_exp_x_s;
        end
    end

    // Stage-1 register: normalized significand, round bits and specials.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_mant_r   <= {N{1'b0}};
            s1_guard_r  <= 1'b0;
            s1_sticky_r <= 1'b0;
            s1_exp_r    <= EXP_ZERO;
            s1_sign_r   <= 1'b0;
            s1_nan_r    <= 1'b0;
            s1_inf_r    <= 1'b0;
            s1_zero_r   <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mant_r   <= norm_mant_s;
                s1_guard_r  <= norm_guard_s;
                s1_sticky_r <= norm_sticky_s;
                s1_exp_r    <= norm_exp_s;
                s1_sign_r   <= in_sign;
                s1_nan_r    <= in_nan;
                s1_inf_r    <= in_inf;
                s1_zero_r   <= in_zero;
            end
        end
    end

    // Rounding: the fraction add wraps to zero exactly when the full mantissa carries out.
    assign round_up_s = s1_guard_r & (s1_sticky_r | s1_mant_r[0]);
    assign carry_s    = round_up_s & (&s1_mant_r);
    assign frac_s     = s1_mant_r[N-2:0] + {{(N-2){1'b0}}, round_up_s};
    assign exp_fin_s  = carry_s ? (s1_exp_r + EXP_ONE) : s1_exp_r;

    // Stage-2 result selection: specials first, then exponent range, then normal pack.
    always_comb begin
        res_s     = {1'b0, exp_fin_s[EW-1:0], frac_s};
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        inexact_s = 1'b0;
        if (s1_nan_r) begin
            res_s = {1'b0, {EW{1'b1}}, 1'b1, {(N-2){1'b0}}};
        end else if (s1_inf_r) begin
            res_s = {s1_sign_r, {EW{1'b1}}, {(N-1){1'b0}}};
        end else if (s1_zero_r) begin
            res_s = {s1_sign_r, {EW{1'b0}}, {(N-1){1'b0}}};
        end else if (exp_fin_s >= EXP_MAX) begin
            res_s     = {s1_sign_r, {EW{1'b1}}, {(N-1){1'b0}}};
            ovf_s     = 1'b1;
            inexact_s = 1'b1;
        end else if (exp_fin_s <= EXP_ZERO) begin
            res_s     = {s1_sign_r, {EW{1'b0}}, {(N-1){1'b0}}};
            unf_s     = 1'b1;
            inexact_s = 1'b1;
        end else begin
            res_s     = {s1_sign_r, exp_fin_s[EW-1:0], frac_s};
            inexact_s = s1_guard_r | s1_sticky_r;
        end
    end

    // Output register: holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= {(EW+N){1'b0}};
            out_ovf_r     <= 1'b0;
            out_unf_r     <= 1'b0;
            out_inexact_r <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_result_r  <= res_s;
                out_ovf_r     <= ovf_s;
                out_unf_r     <= unf_s;
                out_inexact_r <= inexact_s;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_ovf     = out_ovf_r;
    assign out_unf     = out_unf_r;
    assign out_inexact = out_inexact_r;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed vectors, backpressure stream
// and mid-flight reset, with expected results queued at drive time.
module tb_fp_mul_norm_round;

    localparam int N  = 11;
    localparam int EW = 5;

    typedef struct packed {
        logic [2*N-1:0] p;
        logic [EW+1:0]  e;
        logic           s;
        logic           n;
        logic           i;
        logic           z;
        logic [18:0]    exp_v;   // {result[15:0], ovf, unf, inexact}
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_prod;
    logic [EW+1:0]    in_exp;
    logic             in_sign;
    logic             in_nan;
    logic             in_inf;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [EW+N-1:0]  out_result;
    logic             out_ovf;
    logic             out_unf;
    logic             out_inexact;

    int          tests = 0;
    int          fails = 0;
    logic [18:0] q[$];

    fp_mul_norm_round #(.N(N), .EW(EW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: integer shift/remainder rounding, independent of the RTL structure.
    function automatic logic [18:0] model(input logic [21:0] p, input logic [6:0] e,
                                          input logic s, input logic n,
                                          input logic i, input logic z);
        int unsigned pv, m, rem, half;
        int ex, sh;
        logic inx;
        if (n) return {16'h7E00, 3'b000};
        if (i) return {s, 5'h1F, 10'h000, 3'b000};
        if (z) return {s, 15'h0000, 3'b000};
        pv   = 32'(p);
        sh   = p[21] ? 11 : 10;
        ex   = int'($signed(e)) + (p[21] ? 1 : 0);
        m    = pv >> sh;
        rem  = pv & ((32'd1 << sh) - 32'd1);
        half = 32'd1 << (sh - 1);
        inx  = (rem != 32'd0);
        if (rem > half || (rem == half && m[0])) m = m + 32'd1;
        if (m >= 32'd2048) begin
            m  = m >> 1;
            ex = ex + 1;
        end
        if (ex >= 31) return {s, 5'h1F, 10'h000, 3'b101};
        if (ex <= 0)  return {s, 15'h0000, 3'b011};
        return {s, ex[4:0], m[9:0], 2'b00, inx};
    endfunction

    // Drives one beat starting at posedge+1; returns at posedge+1 after the transfer.
    task automatic send_beat(input vec_t v, output bit to);
        in_prod  = v.p;
        in_exp   = v.e;
        in_sign  = v.s;
        in_nan   = v.n;
        in_inf   = v.i;
        in_zero  = v.z;
        in_valid = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                q.push_back(v.exp_v);
                to = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat counts cycles including the input cycle.
    task automatic collect(output logic [18:0] obs, output int lat, output bit to);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to  = !out_valid;
        obs = {out_result, out_ovf, out_unf, out_inexact};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_prod = '0; in_exp = '0; in_sign = 1'b0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 00000",
                     {out_valid, out_result, out_ovf, out_unf, out_inexact});
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t v[$];
        logic [18:0] obs, ev;
        int lat;
        bit sto, cto;
        v.push_back('{22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4080, 3'b000}});
        v.push_back('{22'h180600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3E02, 3'b001}});
        v.push_back('{22'h181200, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3E04, 3'b001}});
        v.push_back('{22'h3FFC00, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4400, 3'b001}});
        v.push_back('{22'h240000, 7'd30, 1'b0, 1'b0, 1'b0, 1'b0, {16'h7C00, 3'b101}});
        v.push_back('{22'h3FFC00, 7'd29, 1'b0, 1'b0, 1'b0, 1'b0, {16'h7C00, 3'b101}});
        v.push_back('{22'h100000, 7'd0,  1'b1, 1'b0, 1'b0, 1'b0, {16'h8000, 3'b011}});
        v.push_back('{22'h200000, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b011}});
        v.push_back('{22'h100000, 7'd1,  1'b0, 1'b0, 1'b0, 1'b0, {16'h0400, 3'b000}});
        v.push_back('{22'h240000, 7'd15, 1'b0, 1'b1, 1'b1, 1'b0, {16'h7E00, 3'b000}});
        v.push_back('{22'h240000, 7'd15, 1'b1, 1'b0, 1'b1, 1'b0, {16'hFC00, 3'b000}});
        v.push_back('{22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b1, {16'h0000, 3'b000}});
        out_ready = 1'b1;
        foreach (v[k]) begin
            send_beat(v[k], sto);
            collect(obs, lat, cto);
            ev = (q.size() != 0) ? q.pop_front() : 19'h0;
            tests++;
            if (sto || cto) begin
                fails++;
                $display("FAIL directed_timeout[%0d]: got none expected %h", k, v[k].exp_v);
            end else if (obs !== ev) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h expected %h", k, obs, ev);
            end
            tests++;
            if (lat !== 2) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d expected 2", k, lat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        vec_t        b[8];
        int          sent = 0, got = 0, occ = 0, cyc = 0;
        logic [18:0] prev_out = '0, ev;
        logic        prev_stall = 1'b0, exp_rdy, xin, xout;
        for (int k = 0; k < 8; k++) begin
            b[k].p = 22'($urandom);
            if (!b[k].p[21]) b[k].p[20] = 1'b1;
            b[k].e = 7'($urandom_range(0, 40)) - 7'd5;
            b[k].s = 1'($urandom_range(0, 1));
            b[k].n = ($urandom_range(0, 9) == 0);
            b[k].i = ($urandom_range(0, 9) == 0);
            b[k].z = ($urandom_range(0, 9) == 0);
            b[k].exp_v = model(b[k].p, b[k].e, b[k].s, b[k].n, b[k].i, b[k].z);
        end
        while (got < 8 && cyc < 200) begin
            if (prev_stall) begin
                tests++;
                if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== {1'b1, prev_out}) begin
                    fails++;
                    $display("FAIL stall_hold: got %h expected %h",
                             {out_valid, out_result, out_ovf, out_unf, out_inexact}, {1'b1, prev_out});
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_prod = b[sent].p; in_exp = b[sent].e; in_sign = b[sent].s;
                in_nan = b[sent].n; in_inf = b[sent].i; in_zero = b[sent].z;
            end
            #1;
            exp_rdy = !(occ == 2 && !out_ready);
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL stream_in_ready: got %b expected %b", in_ready, exp_rdy);
            end
            xin  = in_valid && in_ready;
            xout = out_valid && out_ready;
            if (xout) begin
                ev = (q.size() != 0) ? q.pop_front() : 19'h0;
                tests++;
                if ({out_result, out_ovf, out_unf, out_inexact} !== ev) begin
                    fails++;
                    $display("FAIL stream_result[%0d]: got %h expected %h",
                             got, {out_result, out_ovf, out_unf, out_inexact}, ev);
                end
                got++;
                occ--;
            end
            if (xin) begin
                q.push_back(b[sent].exp_v);
                sent++;
                occ++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_result, out_ovf, out_unf, out_inexact};
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (got != 8 || q.size() != 0) begin
            fails++;
            $display("FAIL stream_count: got %0d results expected 8 (queue left %0d)", got, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        vec_t        a, c;
        logic [18:0] obs, ev;
        int          lat;
        bit          t1, t2, t3, cto;
        a = '{22'h240000, 7'd20, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0};
        c = '{22'h180600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3E02, 3'b001}};
        out_ready = 1'b0;
        send_beat(a, t1);
        send_beat(a, t2);
        tests++;
        if (t1 || t2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_in_ready: got %b expected 0", in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
        out_ready = 1'b1;
        send_beat(c, t3);
        collect(obs, lat, cto);
        ev = (q.size() != 0) ? q.pop_front() : 19'h0;
        tests++;
        if (t3 || cto || obs !== ev || lat !== 2) begin
            fails++;
            $display("FAIL postreset_beat: got %h lat %0d expected %h lat 2", obs, lat, ev);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stale_output: got valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
